mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator side of the CPU's dual-port main memory interface. Accepts instruction-fetch, load and store requests from the pipeline, drives the two combinational read ports and the single synchronous write port, and returns registered read responses. Stores are decoupled through a small in-order store buffer. Loads are kept coherent with buffered stores by forwarding or by stalling.

## Interface
- `ADDR_W`, 32, word address width; memory is word-addressed.
- `DATA_W`, 32, data word width.
- `SB_DEPTH`, 4, store-buffer entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_valid` in 1: fetch request; always accepted.
- `fetch_addr` in ADDR_W: fetch word address.
- `fetch_rsp_valid` out 1: fetch response valid.
- `fetch_rsp_data` out DATA_W: fetched word.
- `ld_valid` in 1: load request.
- `ld_ready` out 1: load accepted when `ld_valid && ld_ready`.
- `ld_addr` in ADDR_W: load word address.
- `ld_rsp_valid` out 1: load response valid.
- `ld_rsp_data` out DATA_W: loaded word.
- `st_valid` in 1: store request.
- `st_ready` out 1: store accepted when `st_valid && st_ready`.
- `st_addr` in ADDR_W: store word address.
- `st_data` in DATA_W: store data.
- `sb_hold` in 1: pauses draining of the store buffer.
- `sb_empty` out 1: store buffer holds no entries.
- `mem_read_address_0` out ADDR_W: memory read port 0, carries fetches.
- `mem_read_address_1` out ADDR_W: memory read port 1, carries loads.
- `mem_read_data_0` in DATA_W: combinational read data, port 0.
- `mem_read_data_1` in DATA_W: combinational read data, port 1.
- `mem_write_address` out ADDR_W: memory write address.
- `mem_write_data` out DATA_W: memory write data.
- `mem_write_enable` out 1: memory write strobe; memory commits the write on the next `clk` edge.

## Operation
- **Fetch path**
  - `mem_read_address_0 = fetch_addr`, combinationally.
  - On each edge, `fetch_rsp_valid <= fetch_valid` and `fetch_rsp_data <= mem_read_data_0`.
- **Load path**
  - `mem_read_address_1 = ld_addr`.
  - On an accepted load, the registered response is the memory word, unless forwarding applies.
- **Store buffer**
  - Circular FIFO: `SB_DEPTH` entries of {addr, data}, with head pointer, tail pointer and count; pointers wrap modulo `SB_DEPTH`.
  - `st_ready = (count != SB_DEPTH)`.
  - Drain: when `count != 0 && !sb_hold`, the head entry drives `mem_write_*` with `mem_write_enable = 1`; the head pops at the edge.
  - When draining stops, `mem_write_enable = 0`; the address and data outputs hold the head entry, or 0 when empty.
  - Enqueue and drain may occur in the same cycle; count is then unchanged. When full, an enqueue is not possible, but the drain still proceeds.
- **Hazard check**
  - Compare `ld_addr` against every valid entry, including the entry draining this cycle, whose write is not yet visible.
  - A store accepted in the same cycle as a load is younger than that load; it is not compared, and the load returns the older value.
- `sb_empty = (count == 0)`.
- **Reset**: asserting `rst` at any time clears the pointers and count, discards pending stores, and clears both response-valid outputs.

## Timing
- Fetch and load latency: exactly 1 cycle from request to response-valid. Throughput is one fetch and one load per cycle.
- A store becomes memory-visible at the edge that ends its drain cycle. The minimum is 2 edges after acceptance.
- Output values under reset:
  - `fetch_rsp_valid = 0`, `ld_rsp_valid = 0`.
  - `fetch_rsp_data = 0`, `ld_rsp_data = 0`.
  - `sb_empty = 1`, `st_ready = 1`.
  - `mem_write_enable = 0`, `mem_write_address = 0`, `mem_write_data = 0`.
  - `ld_ready = 1`.
- Response data registers load only when the corresponding request is accepted; otherwise they hold their value.

## Configuration
- Macro: `MEM_ACCESS_STORE_FORWARD_EN`.
- Defined:
  - `ld_ready = 1` always.
  - On an address match, `ld_rsp_data` takes the data of the youngest matching entry, by age from the head.
- Undefined:
  - `ld_ready = 0` while any valid entry matches `ld_addr`; the load stalls until that entry drains.
  - If `sb_hold` stays high, the load stalls indefinitely. This is the intended behaviour.

## Structure
- Shared package `mem_access_pkg` holds:
  - the `sb_entry_t` struct {addr, data};
  - the default `ADDR_W`, `DATA_W` and `SB_DEPTH` constants.
- One sub-module, `store_buffer`. It contains:
  - the FIFO, with the count, `st_ready` and `sb_empty` logic;
  - the address-match and youngest-match priority logic.
- It exposes a match flag and the matched data.
- The top level contains the fetch and load response registers and the forwarding or stall mux.

## Test plan
- **Fetch after reset**: memory preloaded with `mem[5]=0xAAAA0001`, then fetch addr 5 → next cycle `fetch_rsp_valid=1`, data `0xAAAA0001`.
- **Store then load, same cycle pair**:
  - store (10, `0x1234`), then load 10 on the next cycle.
  - With the macro: response `0x1234` one cycle later.
  - Without the macro: `ld_ready=0` for one cycle, then response `0x1234`.
- **Youngest match**:
  - With `sb_hold=1`, store (7,`0x1`) then (7,`0x2`), then load 7.
  - With the macro: response `0x2`.
  - Without the macro: stall until hold is released and both entries drain, then `0x2`.
- **Full buffer**: `sb_hold=1`, four stores → `st_ready=0`. Release hold → one write per cycle in FIFO order, `sb_empty=1` after 4 cycles.
- **Same-cycle load and store to addr 3**, old `mem[3]=0x9`: load returns `0x9` and `ld_ready` stays 1; the later load returns the new data.
- **Reset mid-drain**: three entries pending, assert `rst` → `sb_empty=1`, `mem_write_enable=0` immediately, and no further memory writes.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and default sizing for the memory access unit.
package mem_access_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_SB_DEPTH = 4;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// In-order store buffer: circular FIFO that drains into the memory write port,
// plus the youngest-match lookup used to keep loads coherent with pending stores.
module store_buffer
    import mem_access_pkg::*;
#(
    parameter int SB_DEPTH = DEF_SB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DEF_ADDR_W-1:0] i_addr,
    input  logic [DEF_DATA_W-1:0] i_data,
    input  logic                  i_hold,
    input  logic [DEF_ADDR_W-1:0] i_ld_addr,
    output logic                  o_st_ready,
    output logic                  o_empty,
    output logic                  o_wr_en,
    output logic [DEF_ADDR_W-1:0] o_wr_addr,
    output logic [DEF_DATA_W-1:0] o_wr_data,
    output logic                  o_match,
    output logic [DEF_DATA_W-1:0] o_match_data
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    sb_entry_t        r_entries [SB_DEPTH];

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full     = (r_count == CNT_W'(SB_DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_st_ready = !w_full;
    assign w_push     = i_push && !w_full;
    assign w_pop      = !o_empty && !i_hold;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // NOTE: entry storage has no reset; validity comes solely from the count, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (w_push) r_entries[r_tail] <= '{addr: i_addr, data: i_data};
    end

    assign o_wr_en   = w_pop;
    assign o_wr_addr = o_empty ? '0 : r_entries[r_head].addr;
    assign o_wr_data = o_empty ? '0 : r_entries[r_head].data;

    // Walk from oldest to youngest so the last hit wins; the draining head is still included.
    // NOTE: outputs get defaults before the loop so no latch is inferred.
    always_comb begin
        o_match      = 1'b0;
        o_match_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((CNT_W'(i) < r_count) &&
                (r_entries[r_head + PTR_W'(i)].addr == i_ld_addr)) begin
                o_match      = 1'b1;
                o_match_data = r_entries[r_head + PTR_W'(i)].data;
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU main-memory initiator: fetch/load read ports, store buffer drain, registered responses.
// MEM_ACCESS_STORE_FORWARD_EN: forward buffered store data to loads instead of stalling them.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SB_DEPTH = DEF_SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_rsp_valid,
    output logic [DATA_W-1:0] fetch_rsp_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_rsp_valid,
    output logic [DATA_W-1:0] ld_rsp_data,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              sb_hold,
    output logic              sb_empty,
    output logic [ADDR_W-1:0] mem_read_address_0,
    output logic [ADDR_W-1:0] mem_read_address_1,
    input  logic [DATA_W-1:0] mem_read_data_0,
    input  logic [DATA_W-1:0] mem_read_data_1,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable
);

    logic              w_match;
    logic [DATA_W-1:0] w_match_data;
    logic              w_ld_fire;
    logic [DATA_W-1:0] w_ld_data;

    logic              r_fetch_valid;
    logic [DATA_W-1:0] r_fetch_data;
    logic              r_ld_valid;
    logic [DATA_W-1:0] r_ld_data;

    store_buffer #(
        .SB_DEPTH (SB_DEPTH)
    ) u_store_buffer (
        .clk          (clk),
        .rst          (rst),
        .i_push       (st_valid),
        .i_addr       (st_addr),
        .i_data       (st_data),
        .i_hold       (sb_hold),
        .i_ld_addr    (ld_addr),
        .o_st_ready   (st_ready),
        .o_empty      (sb_empty),
        .o_wr_en      (mem_write_enable),
        .o_wr_addr    (mem_write_address),
        .o_wr_data    (mem_write_data),
        .o_match      (w_match),
        .o_match_data (w_match_data)
    );

    assign mem_read_address_0 = fetch_addr;
    assign mem_read_address_1 = ld_addr;

`ifdef MEM_ACCESS_STORE_FORWARD_EN
    assign ld_ready  = 1'b1;
    assign w_ld_data = w_match ? w_match_data : mem_read_data_1;
`else
    // A pending store to the same word blocks the load until it has drained.
    assign ld_ready  = !w_match;
    assign w_ld_data = mem_read_data_1;
`endif

    assign w_ld_fire = ld_valid && ld_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= '0;
            r_ld_valid    <= 1'b0;
            r_ld_data     <= '0;
        end else begin
            r_fetch_valid <= fetch_valid;
            r_ld_valid    <= w_ld_fire;
            if (fetch_valid) r_fetch_data <= mem_read_data_0;
            if (w_ld_fire)   r_ld_data    <= w_ld_data;
        end
    end

    assign fetch_rsp_valid = r_fetch_valid;
    assign fetch_rsp_data  = r_fetch_data;
    assign ld_rsp_valid    = r_ld_valid;
    assign ld_rsp_data     = r_ld_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small behavioural dual-port memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_data;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        sb_hold;
    logic        sb_empty;
    logic [31:0] mem_read_address_0;
    logic [31:0] mem_read_address_1;
    logic [31:0] mem_read_data_0;
    logic [31:0] mem_read_data_1;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;

    logic [31:0] mem [64];
    logic        mem_init;
    int          wr_cnt = 0;
    int          wr_snap;
    int          n_checks = 0;
    int          n_pass = 0;

    mem_access_unit dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_valid        (fetch_valid),
        .fetch_addr         (fetch_addr),
        .fetch_rsp_valid    (fetch_rsp_valid),
        .fetch_rsp_data     (fetch_rsp_data),
        .ld_valid           (ld_valid),
        .ld_ready           (ld_ready),
        .ld_addr            (ld_addr),
        .ld_rsp_valid       (ld_rsp_valid),
        .ld_rsp_data        (ld_rsp_data),
        .st_valid           (st_valid),
        .st_ready           (st_ready),
        .st_addr            (st_addr),
        .st_data            (st_data),
        .sb_hold            (sb_hold),
        .sb_empty           (sb_empty),
        .mem_read_address_0 (mem_read_address_0),
        .mem_read_address_1 (mem_read_address_1),
        .mem_read_data_0    (mem_read_data_0),
        .mem_read_data_1    (mem_read_data_1),
        .mem_write_address  (mem_write_address),
        .mem_write_data     (mem_write_data),
        .mem_write_enable   (mem_write_enable)
    );

    always #5 clk = ~clk;

    assign mem_read_data_0 = mem[mem_read_address_0[5:0]];
    assign mem_read_data_1 = mem[mem_read_address_1[5:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= (i == 5) ? 32'hAAAA_0001 : (i == 3) ? 32'h9 : 32'h0;
        end else if (mem_write_enable) begin
            mem[mem_write_address[5:0]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        fetch_valid = 0; fetch_addr = 0; ld_valid = 0; ld_addr = 0;
        st_valid = 0; st_addr = 0; st_data = 0; sb_hold = 0;
        repeat (3) step();
        mem_init = 1'b0;

        // Reset values
        check("rst_fetch_valid", 32'(fetch_rsp_valid), 0);
        check("rst_fetch_data", fetch_rsp_data, 0);
        check("rst_ld_valid", 32'(ld_rsp_valid), 0);
        check("rst_ld_data", ld_rsp_data, 0);
        check("rst_sb_empty", 32'(sb_empty), 1);
        check("rst_st_ready", 32'(st_ready), 1);
        check("rst_ld_ready", 32'(ld_ready), 1);
        check("rst_wr_en", 32'(mem_write_enable), 0);
        check("rst_wr_addr", mem_write_address, 0);
        check("rst_wr_data", mem_write_data, 0);
        rst = 1'b0;
        step();

        // Fetch after reset
        fetch_valid = 1; fetch_addr = 5;
        #1 check("fetch_rd_addr", mem_read_address_0, 5);
        step();
        fetch_valid = 0;
        check("fetch_rsp_valid", 32'(fetch_rsp_valid), 1);
        check("fetch_rsp_data", fetch_rsp_data, 32'hAAAA_0001);
        step();
        check("fetch_rsp_valid_drop", 32'(fetch_rsp_valid), 0);

        // Store then load of the same word on the next cycle
        st_valid = 1; st_addr = 10; st_data = 32'h1234;
        #1 check("st_ready_empty", 32'(st_ready), 1);
        step();
        st_valid = 0; ld_valid = 1; ld_addr = 10;
        #1 check("drain_wr_en", 32'(mem_write_enable), 1);
        check("drain_wr_addr", mem_write_address, 10);
        check("ld_rd_addr", mem_read_address_1, 10);
`ifdef MEM_ACCESS_STORE_FORWARD_EN
        check("fwd_ld_ready", 32'(ld_ready), 1);
        step();
`else
        check("stall_ld_ready", 32'(ld_ready), 0);
        step();
        check("stall_no_rsp", 32'(ld_rsp_valid), 0);
        #1 check("stall_release", 32'(ld_ready), 1);
        step();
`endif
        ld_valid = 0;
        check("ld10_valid", 32'(ld_rsp_valid), 1);
        check("ld10_data", ld_rsp_data, 32'h1234);
        step();
        check("ld10_valid_drop", 32'(ld_rsp_valid), 0);
        check("ld10_data_hold", ld_rsp_data, 32'h1234);
        check("mem10", mem[10], 32'h1234);

        // Youngest of two matching entries
        sb_hold = 1;
        st_valid = 1; st_addr = 7; st_data = 32'h1;
        step();
        st_data = 32'h2;
        step();
        st_valid = 0; ld_valid = 1; ld_addr = 7;
`ifdef MEM_ACCESS_STORE_FORWARD_EN
        #1 check("young_ld_ready", 32'(ld_ready), 1);
        step();
        ld_valid = 0;
        check("young_valid", 32'(ld_rsp_valid), 1);
        check("young_data", ld_rsp_data, 32'h2);
        sb_hold = 0;
        step();
        step();
`else
        #1 check("young_stall0", 32'(ld_ready), 0);
        step();
        check("young_no_rsp", 32'(ld_rsp_valid), 0);
        sb_hold = 0;
        #1 check("young_stall1", 32'(ld_ready), 0);
        step();
        #1 check("young_stall2", 32'(ld_ready), 0);
        step();
        #1 check("young_release", 32'(ld_ready), 1);
        step();
        ld_valid = 0;
        check("young_valid", 32'(ld_rsp_valid), 1);
        check("young_data", ld_rsp_data, 32'h2);
`endif
        check("young_sb_empty", 32'(sb_empty), 1);
        check("mem7", mem[7], 32'h2);

        // Fill the buffer, then drain in FIFO order with a push landing mid-drain
        sb_hold = 1;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1; st_addr = 32'(20 + i); st_data = 32'h100 + 32'(i);
            #1 check("fill_st_ready", 32'(st_ready), 1);
            step();
        end
        st_valid = 0;
        #1 check("full_st_ready", 32'(st_ready), 0);
        check("full_sb_empty", 32'(sb_empty), 0);
        check("full_wr_en", 32'(mem_write_enable), 0);
        check("full_wr_addr_hold", mem_write_address, 20);
        check("full_wr_data_hold", mem_write_data, 32'h100);
        sb_hold = 0;
        for (int i = 0; i < 5; i++) begin
            st_valid = (i < 2);
            st_addr  = (i == 0) ? 32'd30 : 32'd40;
            st_data  = (i == 0) ? 32'h77 : 32'h55;
            #1 check("drain_en", 32'(mem_write_enable), 1);
            check("drain_addr", mem_write_address, (i < 4) ? 32'(20 + i) : 32'd40);
            check("drain_data", mem_write_data, (i < 4) ? 32'h100 + 32'(i) : 32'h55);
            if (i == 0) check("full_drain_no_push", 32'(st_ready), 0);
            step();
        end
        st_valid = 0;
        #1 check("drained_empty", 32'(sb_empty), 1);
        check("drained_wr_en", 32'(mem_write_enable), 0);
        check("drained_wr_addr", mem_write_address, 0);
        check("mem23", mem[23], 32'h103);
        check("mem40", mem[40], 32'h55);
        check("mem30_rejected", mem[30], 32'h0);

        // Same-cycle load and store to word 3: load sees the old value
        st_valid = 1; st_addr = 3; st_data = 32'h33; ld_valid = 1; ld_addr = 3;
        #1 check("same_ld_ready", 32'(ld_ready), 1);
        step();
        st_valid = 0;
        check("same_old_valid", 32'(ld_rsp_valid), 1);
        check("same_old_data", ld_rsp_data, 32'h9);
`ifndef MEM_ACCESS_STORE_FORWARD_EN
        #1 check("same_next_stall", 32'(ld_ready), 0);
        step();
        check("same_stall_no_rsp", 32'(ld_rsp_valid), 0);
`endif
        step();
        ld_valid = 0;
        check("same_new_valid", 32'(ld_rsp_valid), 1);
        check("same_new_data", ld_rsp_data, 32'h33);
        step();

        // Reset while three stores are pending
        sb_hold = 1;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1; st_addr = 32'(50 + i); st_data = 32'hA0 + 32'(i);
            step();
        end
        st_valid = 0; sb_hold = 0;
        #1 check("pre_rst_wr_en", 32'(mem_write_enable), 1);
        check("pre_rst_wr_addr", mem_write_address, 50);
        wr_snap = wr_cnt;
        rst = 1;
        #1 check("mid_rst_sb_empty", 32'(sb_empty), 1);
        check("mid_rst_wr_en", 32'(mem_write_enable), 0);
        check("mid_rst_wr_addr", mem_write_address, 0);
        check("mid_rst_st_ready", 32'(st_ready), 1);
        step();
        step();
        rst = 0;
        step();
        step();
        check("post_rst_writes", 32'(wr_cnt), 32'(wr_snap));
        check("post_rst_sb_empty", 32'(sb_empty), 1);
        check("mem50_untouched", mem[50], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
